// File: rtl/i2c_capture_pkg.sv
// Shared types for the passive I2C transaction capture block.
package i2c_capture_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    REC_START  = 2'd0,
    REC_BYTE   = 2'd1,
    REC_STOP   = 2'd2,
    REC_RSTART = 2'd3
  } rec_kind_e;

  typedef struct packed {
    rec_kind_e         kind;
    logic [DATA_W-1:0] data;
    logic              ack;
  } i2c_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BITS = 2'd1,
    ST_ACK  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/i2c_capture_fifo.sv
// First-word-fall-through record buffer with sticky overflow and synchronous flush.
module i2c_capture_fifo
  import i2c_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear,
  input  logic     push,
  input  i2c_rec_t push_rec,
  input  logic     pop_ready,
  output logic     valid_c,
  output i2c_rec_t head_c,
  output logic     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  i2c_rec_t      mem [DEPTH];

  logic full_c;
  logic pop_c;
  logic wr_en_c;
  logic ovf_set_c;

  assign valid_c   = (count != '0);
  assign full_c    = (count == CW'(DEPTH));
  assign pop_c     = pop_ready & valid_c;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign wr_en_c   = push & ~clear & (~full_c | pop_c);
  assign ovf_set_c = push & ~clear & full_c & ~pop_c;
  assign head_c    = valid_c ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set_c) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= push_rec;
  end

endmodule

// File: rtl/i2c_txn_capture.sv
// Passive I2C observer: decodes START/RSTART/STOP/BYTE events into a valid/ready record stream.
module i2c_txn_capture
  import i2c_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic              clear_i,
  input  logic              rec_ready_i,
  output logic              rec_valid_o,
  output logic [1:0]        rec_kind_o,
  output logic [DATA_W-1:0] rec_data_o,
  output logic              rec_ack_o,
  output logic              overflow_o,
  output logic              bus_busy_o
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  // Synchronizers and delayed copies idle high, matching a released bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_rise_c;
  logic start_c;
  logic stop_c;

  // Requiring SCL high on both samples lets a simultaneous SCL edge mask the SDA change.
  assign scl_rise_c = scl_s & ~scl_d;
  assign start_c    = scl_s & scl_d &  sda_d & ~sda_s;
  assign stop_c     = scl_s & scl_d & ~sda_d &  sda_s;

  fsm_state_e           state, state_n;
  logic [BIT_CNT_W-1:0] bitcnt, bitcnt_n;
  logic [DATA_W-1:0]    shreg, shreg_n;
  logic                 busy, busy_n;
  logic                 push_c;
  i2c_rec_t             rec_c;
  logic                 push_q;
  i2c_rec_t             rec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      busy   <= 1'b0;
      push_q <= 1'b0;
      rec_q  <= '0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      busy   <= busy_n;
      push_q <= push_c;
      rec_q  <= rec_c;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    busy_n   = busy;
    push_c   = 1'b0;
    rec_c    = '0;
    if (start_c) begin
      push_c     = 1'b1;
      rec_c.kind = (state == ST_IDLE) ? REC_START : REC_RSTART;
      busy_n     = 1'b1;
      bitcnt_n   = '0;
      shreg_n    = '0;
      state_n    = ST_BITS;
    end else if (stop_c && (state != ST_IDLE)) begin
      push_c     = 1'b1;
      rec_c.kind = REC_STOP;
      busy_n     = 1'b0;
      bitcnt_n   = '0;
      state_n    = ST_IDLE;
    end else if (scl_rise_c) begin
      case (state)
        ST_BITS: begin
          shreg_n  = {shreg[DATA_W-2:0], sda_s};
          bitcnt_n = bitcnt + BIT_CNT_W'(1);
          if (bitcnt == BIT_CNT_W'(DATA_W - 1)) state_n = ST_ACK;
        end
        ST_ACK: begin
          push_c     = 1'b1;
          rec_c.kind = REC_BYTE;
          rec_c.data = shreg;
          rec_c.ack  = ~sda_s;
          bitcnt_n   = '0;
          state_n    = ST_BITS;
        end
        default: ;
      endcase
    end
  end

  i2c_rec_t head_c;

  i2c_capture_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_i),
    .push      (push_q),
    .push_rec  (rec_q),
    .pop_ready (rec_ready_i),
    .valid_c   (rec_valid_o),
    .head_c    (head_c),
    .overflow  (overflow_o)
  );

  assign rec_kind_o = head_c.kind;
  assign rec_data_o = head_c.data;
  assign rec_ack_o  = head_c.ack;
  assign bus_busy_o = busy;

endmodule

// File: tb/tb_i2c_txn_capture.sv
// Bench for i2c_txn_capture: bit-level I2C master model feeding a record scoreboard.
module tb_i2c_txn_capture;

  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned Q           = 4;
  localparam logic [1:0] K_START  = 2'd0;
  localparam logic [1:0] K_BYTE   = 2'd1;
  localparam logic [1:0] K_STOP   = 2'd2;
  localparam logic [1:0] K_RSTART = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       clear = 1'b0;
  logic       ready = 1'b0;
  logic       rec_valid;
  logic [1:0] rec_kind;
  logic [7:0] rec_data;
  logic       rec_ack;
  logic       overflow;
  logic       bus_busy;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  i2c_txn_capture #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl),
    .sda_i       (sda),
    .clear_i     (clear),
    .rec_ready_i (ready),
    .rec_valid_o (rec_valid),
    .rec_kind_o  (rec_kind),
    .rec_data_o  (rec_data),
    .rec_ack_o   (rec_ack),
    .overflow_o  (overflow),
    .bus_busy_o  (bus_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic q_wait;
    repeat (Q) @(negedge clk);
  endtask

  task automatic expect_rec(input logic [1:0] k, input logic [7:0] d, input logic a);
    sb.push_back({k, d, a});
  endtask

  task automatic i2c_start(input logic [1:0] k);
    sda = 1'b1; q_wait;
    scl = 1'b1; q_wait;
    sda = 1'b0; expect_rec(k, 8'h00, 1'b0); q_wait;
    scl = 1'b0; q_wait;
  endtask

  task automatic i2c_stop(input bit do_exp);
    sda = 1'b0; q_wait;
    scl = 1'b1; q_wait;
    sda = 1'b1;
    if (do_exp) expect_rec(K_STOP, 8'h00, 1'b0);
    q_wait;
  endtask

  // skew: SDA returns high on the same clock as SCL falls
  task automatic send_bit(input logic b, input bit skew);
    sda = b; q_wait;
    scl = 1'b1; q_wait;
    scl = 1'b0;
    if (skew) sda = 1'b1;
    q_wait;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack_low, input bit skew,
                           input bit do_exp, input logic [7:0] ed, input logic ea);
    for (int i = 7; i >= 0; i--) send_bit(d[i], skew);
    if (do_exp) expect_rec(K_BYTE, ed, ea);
    send_bit(~ack_low, 1'b0);
  endtask

  task automatic byte_std(input logic [7:0] d, input logic ack_low);
    send_byte(d, ack_low, 1'b0, 1'b1, d, ack_low);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || rec_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Consumer: choose ready on the falling edge; a pop lands on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       ready = 1'b1;
        1:       ready = 1'b0;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_n && rec_valid && ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rec: got kind %0d data 0x%0h ack %0d expected none",
                   rec_kind, rec_data, rec_ack);
        end else begin
          mon_e = sb.pop_front();
          check("rec", 32'({rec_kind, rec_data, rec_ack}), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] tx;
    logic       ack_low;
    logic [7:0] exp_data;
    logic       exp_ack;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   cnt;
    logic [7:0] rd;
    logic       ra;

    vecs[0] = '{8'h54, 1'b1, 8'h54, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 8'hA5, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(rec_valid), 32'd0);
    check("reset_head", 32'({rec_kind, rec_data, rec_ack}), 32'd0);
    check("reset_ovf_busy", 32'({overflow, bus_busy}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single-byte write transfers from the table
    for (int v = 0; v < 4; v++) begin
      i2c_start(K_START);
      check("busy_after_start", 32'(bus_busy), 32'd1);
      send_byte(vecs[v].tx, vecs[v].ack_low, 1'b0, 1'b1, vecs[v].exp_data, vecs[v].exp_ack);
      i2c_stop(1'b1);
      repeat (6) @(negedge clk);
      check("busy_after_stop", 32'(bus_busy), 32'd0);
      wait_drain("drain_table");
    end

    // Address, repeated START, NACKed byte
    i2c_start(K_START);
    byte_std(8'hAA, 1'b1);
    i2c_start(K_RSTART);
    check("busy_rstart", 32'(bus_busy), 32'd1);
    byte_std(8'hAB, 1'b0);
    i2c_stop(1'b1);
    wait_drain("drain_rstart");

    // SDA rising together with SCL falling must not read as STOP
    i2c_start(K_START);
    send_byte(8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
    check("skew_busy", 32'(bus_busy), 32'd1);
    i2c_stop(1'b1);
    wait_drain("drain_skew");

    // Overflow: 10 records into an 8-deep buffer with the consumer stalled
    ready_mode = 1;
    i2c_start(K_START);
    for (int i = 0; i < 8; i++) byte_std(8'(8'h10 + i), 1'b1);
    i2c_stop(1'b1);
    void'(sb.pop_back());
    void'(sb.pop_back());
    repeat (8) @(negedge clk);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_valid", 32'(rec_valid), 32'd1);
    ready_mode = 0;
    wait_drain("drain_ovf");
    check("ovf_sticky", 32'(overflow), 32'd1);

    // clear_i flushes buffered records and the overflow flag
    ready_mode = 1;
    i2c_start(K_START);
    byte_std(8'h77, 1'b1);
    i2c_stop(1'b1);
    repeat (8) @(negedge clk);
    check("pre_clear_valid", 32'(rec_valid), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_valid", 32'(rec_valid), 32'd0);
    check("clear_ovf", 32'(overflow), 32'd0);
    sb.delete();
    ready_mode = 0;
    repeat (4) @(negedge clk);
    check("clear_stays_empty", 32'(rec_valid), 32'd0);

    // STOP after 5 data bits drops the partial byte
    i2c_start(K_START);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1'b0);
    i2c_stop(1'b1);
    wait_drain("drain_partial");
    check("partial_busy", 32'(bus_busy), 32'd0);
    i2c_start(K_START);
    byte_std(8'h3C, 1'b1);
    i2c_stop(1'b1);
    wait_drain("drain_3c");

    // Reset at bit 4, then an orphan STOP that must be ignored
    i2c_start(K_START);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    wait_drain("drain_pre_reset");
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_outputs", 32'({rec_valid, overflow, bus_busy}), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    i2c_stop(1'b0);
    repeat (6) @(negedge clk);
    check("orphan_stop_valid", 32'(rec_valid), 32'd0);
    check("orphan_stop_busy", 32'(bus_busy), 32'd0);
    i2c_start(K_START);
    byte_std(8'h81, 1'b1);
    i2c_stop(1'b1);
    wait_drain("drain_81");

    // Latency from SDA fall to rec_valid with an empty buffer
    sda = 1'b0;
    expect_rec(K_START, 8'h00, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!rec_valid && cnt < 20);
    check("latency", 32'(cnt), 32'(SYNC_STAGES + 2));
    q_wait;
    scl = 1'b0;
    q_wait;

    // 50 random bytes under a randomly stalling consumer
    ready_mode = 2;
    for (int i = 0; i < 50; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      byte_std(rd, ra);
    end
    i2c_stop(1'b1);
    wait_drain("drain_random");
    check("random_no_ovf", 32'(overflow), 32'd0);
    check("random_busy", 32'(bus_busy), 32'd0);
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
